idwt_reconstructor: RTL and testbench

Inverse integer lifting stage for the one-level DWT path: consumes (approximation, detail) coefficient pairs and rebuilds the interleaved sample stream, even sample first, then odd. It sits downstream of coefficient storage/quantisation and undoes the forward predict/update pair, serialising two reconstructed samples per accepted pair under valid/ready flow control on both sides.

---
 rtl/dwt_pkg.sv | 12 +
 rtl/inverse_lift_unit.sv | 20 ++
 rtl/idwt_reconstructor.sv | 103 ++++++++++
 tb/tb_idwt_reconstructor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared definitions for the one-level DWT forward and inverse lifting path.
package dwt_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2
    } dwt_state_e;

endpackage

// File: rtl/inverse_lift_unit.sv
// Combinational inverse lifting: (a, d) -> (x_even, x_odd), all sums wrap modulo 2^DATA_W.
module inverse_lift_unit #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] approx,
    input  logic [DATA_W-1:0] detail,
    output logic [DATA_W-1:0] x_even,
    output logic [DATA_W-1:0] x_odd
);

    // Shift kept in its own signed net so it stays arithmetic, not logical.
    logic signed [DATA_W-1:0] half_d;

    always_comb begin
        half_d = $signed(detail) >>> 1;
        x_even = approx - half_d;
        x_odd  = detail + x_even;
    end

endmodule

// File: rtl/idwt_reconstructor.sv
// Inverse lifting stage: accepts (approx, detail) pairs and emits even then odd samples.
module idwt_reconstructor
    import dwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] approx_in,
    input  logic [DATA_W-1:0] detail_in,
    input  logic              coef_last,
    input  logic              coef_valid,
    output logic              coef_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_last,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [CNT_W-1:0]  pair_cnt,
    output logic              frame_done
);

    dwt_state_e        state_q, state_d;
    logic [DATA_W-1:0] even_q, odd_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] even_w, odd_w;
    logic              accept;
    logic              odd_hs;

    inverse_lift_unit #(.DATA_W(DATA_W)) u_lift (
        .approx (approx_in),
        .detail (detail_in),
        .x_even (even_w),
        .x_odd  (odd_w)
    );

    always_comb begin
        coef_ready   = 1'b0;
        sample_valid = 1'b0;
        sample_out   = '0;
        sample_last  = 1'b0;
        state_d      = state_q;
        case (state_q)
            EMPTY: coef_ready = 1'b1;
            EVEN: begin
                sample_valid = 1'b1;
                sample_out   = even_q;
            end
            ODD: begin
                sample_valid = 1'b1;
                sample_out   = odd_q;
                sample_last  = last_q;
                coef_ready   = sample_ready;
            end
            default: ;
        endcase

        accept = coef_valid && coef_ready;
        odd_hs = (state_q == ODD) && sample_ready;

        case (state_q)
            EMPTY: if (accept) state_d = EVEN;
            EVEN:  if (sample_ready) state_d = ODD;
            ODD:   if (sample_ready) state_d = accept ? EVEN : EMPTY;
            default: state_d = EMPTY;
        endcase

        // Frame end clears the count; a pair accepted in that same cycle starts the next frame at 1.
        frame_done_d = odd_hs && last_q;
        cnt_d        = cnt_q;
        if (frame_done_d) begin
            cnt_d = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            even_q       <= '0;
            odd_q        <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                even_q <= even_w;
                odd_q  <= odd_w;
                last_q <= coef_last;
            end
        end
    end

    assign pair_cnt   = cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_idwt_reconstructor.sv
// Directed bench for idwt_reconstructor with hand-computed reconstruction values.
module tb_idwt_reconstructor;

    logic        clk;
    logic        rst;
    logic [15:0] approx_in, detail_in;
    logic        coef_last, coef_valid, coef_ready;
    logic [15:0] sample_out;
    logic        sample_last, sample_valid, sample_ready;
    logic [15:0] pair_cnt;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    idwt_reconstructor #(.DATA_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .approx_in    (approx_in),
        .detail_in    (detail_in),
        .coef_last    (coef_last),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .sample_out   (sample_out),
        .sample_last  (sample_last),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pair_cnt     (pair_cnt),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame table: a, d and the hand-derived x_even, x_odd for each pair.
    logic [15:0] ta [8] = '{16'h0064, 16'hFFEC, 16'h0000, 16'h0007,
                            16'h012C, 16'hFFFF, 16'h7FFF, 16'h0032};
    logic [15:0] td [8] = '{16'h0006, 16'hFFF9, 16'h0001, 16'hFFFF,
                            16'h0028, 16'h0000, 16'hFFFE, 16'h000B};
    logic [15:0] tx [16] = '{16'h0061, 16'h0067, 16'hFFF0, 16'hFFE9,
                             16'h0000, 16'h0001, 16'h0008, 16'h0007,
                             16'h0118, 16'h0140, 16'hFFFF, 16'hFFFF,
                             16'h8000, 16'h7FFE, 16'h002D, 16'h0038};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] d, input logic last,
                             input logic [15:0] exp_e, input logic [15:0] exp_o,
                             input logic [15:0] exp_cnt);
        approx_in    = a;
        detail_in    = d;
        coef_last    = last;
        coef_valid   = 1'b1;
        sample_ready = 1'b1;
        @(posedge clk); #1;
        coef_valid = 1'b0;
        chk("even_valid", 32'(sample_valid), 32'd1);
        chk("even_out", 32'(sample_out), 32'(exp_e));
        chk("even_last", 32'(sample_last), 32'd0);
        chk("even_coef_ready", 32'(coef_ready), 32'd0);
        chk("even_pair_cnt", 32'(pair_cnt), 32'(exp_cnt));
        @(posedge clk); #1;
        chk("odd_valid", 32'(sample_valid), 32'd1);
        chk("odd_out", 32'(sample_out), 32'(exp_o));
        chk("odd_last", 32'(sample_last), 32'(last));
        chk("odd_coef_ready", 32'(coef_ready), 32'd1);
        @(posedge clk); #1;
        chk("idle_valid", 32'(sample_valid), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'(last));
        chk("idle_pair_cnt", 32'(pair_cnt), last ? 32'd0 : 32'(exp_cnt));
    endtask

    initial begin
        logic [31:0] pat;
        int          tx_idx, rx_idx, cyc;
        logic        will_accept, prev_stall;
        logic [15:0] prev_out;

        rst = 1'b0; approx_in = '0; detail_in = '0; coef_last = 1'b0;
        coef_valid = 1'b0; sample_ready = 1'b0;
        #3;
        chk("rst_coef_ready", 32'(coef_ready), 32'd1);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'd0);
        chk("rst_sample_last", 32'(sample_last), 32'd0);
        chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_coef_ready", 32'(coef_ready), 32'd1);
            chk("idle_sample_valid", 32'(sample_valid), 32'd0);
            chk("idle_cnt", 32'(pair_cnt), 32'd0);
        end

        send_pair(16'd12, 16'd4, 1'b0, 16'd10, 16'd14, 16'd1);
        send_pair(16'd5, 16'hFFFC, 1'b0, 16'd7, 16'd3, 16'd2);
        send_pair(16'd6, 16'd3, 1'b0, 16'd5, 16'd8, 16'd3);
        send_pair(16'd6, 16'hFFFD, 1'b1, 16'd8, 16'd5, 16'd4);
        chk("fd_pulse_end", 32'(frame_done), 32'd1);
        @(posedge clk); #1;
        chk("fd_one_cycle", 32'(frame_done), 32'd0);

        // Back-to-back 8-pair frame, sink always ready.
        sample_ready = 1'b1;
        approx_in = ta[0]; detail_in = td[0]; coef_last = 1'b0; coef_valid = 1'b1;
        for (int s = 0; s < 16; s++) begin
            @(posedge clk); #1;
            chk("bb_valid", 32'(sample_valid), 32'd1);
            chk("bb_out", 32'(sample_out), 32'(tx[s]));
            chk("bb_last", 32'(sample_last), (s == 15) ? 32'd1 : 32'd0);
            chk("bb_frame_done", 32'(frame_done), 32'd0);
            if (s % 2 == 0) begin
                chk("bb_cnt", 32'(pair_cnt), 32'(s / 2 + 1));
                if (s / 2 < 7) begin
                    approx_in = ta[s/2+1]; detail_in = td[s/2+1];
                    coef_last = (s / 2 + 1 == 7);
                end else begin
                    coef_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        chk("bb_end_valid", 32'(sample_valid), 32'd0);
        chk("bb_end_frame_done", 32'(frame_done), 32'd1);
        chk("bb_end_cnt", 32'(pair_cnt), 32'd0);
        @(posedge clk); #1;
        chk("bb_fd_drop", 32'(frame_done), 32'd0);

        // Stalled sink: 4 pairs, last on the 4th, fixed irregular ready pattern.
        pat = 32'b1011_0010_1101_0011_0110_1001_0100_1101;
        tx_idx = 0; rx_idx = 0; prev_stall = 1'b0; prev_out = '0;
        approx_in = ta[0]; detail_in = td[0]; coef_last = 1'b0; coef_valid = 1'b1;
        for (cyc = 0; cyc < 200 && rx_idx < 8; cyc++) begin
            sample_ready = pat[cyc % 32];
            #1;
            if (prev_stall) chk("stall_stable", 32'(sample_out), 32'(prev_out));
            if (sample_valid && rx_idx % 2 == 0) chk("stall_even_coef_ready", 32'(coef_ready), 32'd0);
            if (sample_valid && sample_ready) begin
                chk("stall_out", 32'(sample_out), 32'(tx[rx_idx]));
                chk("stall_last", 32'(sample_last), (rx_idx == 7) ? 32'd1 : 32'd0);
                rx_idx++;
            end
            prev_stall  = sample_valid && !sample_ready;
            prev_out    = sample_out;
            will_accept = coef_valid && coef_ready;
            @(posedge clk); #1;
            if (will_accept) begin
                tx_idx++;
                if (tx_idx < 4) begin
                    approx_in = ta[tx_idx]; detail_in = td[tx_idx]; coef_last = (tx_idx == 3);
                end else begin
                    coef_valid = 1'b0;
                end
            end
        end
        chk("stall_all_received", 32'(rx_idx), 32'd8);
        chk("stall_frame_done", 32'(frame_done), 32'd1);
        chk("stall_cnt", 32'(pair_cnt), 32'd0);

        // Reset while holding an even sample of a last-flagged pair.
        sample_ready = 1'b0;
        approx_in = 16'd12; detail_in = 16'd4; coef_last = 1'b1; coef_valid = 1'b1;
        @(posedge clk); #1;
        coef_valid = 1'b0;
        chk("pre_rst_valid", 32'(sample_valid), 32'd1);
        chk("pre_rst_cnt", 32'(pair_cnt), 32'd1);
        #2; rst = 1'b0; #1;
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_out", 32'(sample_out), 32'd0);
        chk("mid_rst_coef_ready", 32'(coef_ready), 32'd1);
        chk("mid_rst_cnt", 32'(pair_cnt), 32'd0);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_fd", 32'(frame_done), 32'd0);
        send_pair(16'd6, 16'd3, 1'b0, 16'd5, 16'd8, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
